// File: rtl/bus_fabric.sv
// bus_fabric: single-master interconnect between the CPU port and N slaves.
// Registered request/response paths, one outstanding read tracked by a small
// FSM with a per-read timeout, and a sticky error flag for bad accesses.
module bus_fabric #(
   parameter int                N_SLAVES = 4,
   parameter int                ADDR_W   = 16,
   parameter int                SEL_W    = 4,
   parameter int                DATA_W   = 32,
   parameter int                TIMEOUT  = 15,
   parameter logic [DATA_W-1:0] ERR_DATA = 32'hDEADBEEF
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         m_rd_en,
   input  logic [ADDR_W-1:0]            m_rd_addr,
   output logic [DATA_W-1:0]            m_rd_data,
   output logic                         m_rd_valid,
   input  logic                         m_wr_en,
   input  logic [ADDR_W-1:0]            m_wr_addr,
   input  logic [DATA_W-1:0]            m_wr_data,
   output logic [N_SLAVES-1:0]          s_rd_en,
   output logic [ADDR_W-1:0]            s_rd_addr,
   input  logic [N_SLAVES*DATA_W-1:0]   s_rd_data,
   input  logic [N_SLAVES-1:0]          s_rd_valid,
   output logic [N_SLAVES-1:0]          s_wr_en,
   output logic [ADDR_W-1:0]            s_wr_addr,
   output logic [DATA_W-1:0]            s_wr_data,
   output logic                         err,
   output logic [ADDR_W-1:0]            err_addr,
   input  logic                         err_clr
);

   localparam int               CNT_W     = $clog2(TIMEOUT + 1);
   localparam int               OFF_W     = ADDR_W - SEL_W;
   localparam logic [SEL_W:0]   SLV_LIMIT = N_SLAVES[SEL_W:0];
   localparam logic [CNT_W-1:0] CNT_LAST  = TIMEOUT[CNT_W-1:0];
   localparam logic [CNT_W-1:0] CNT_ONE   = 1;

   typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

   state_t              state;
   state_t              state_next;
   logic [SEL_W-1:0]    sel_q;
   logic [ADDR_W-1:0]   rd_addr_q;
   logic [CNT_W-1:0]    cnt;
   logic                issue;
   logic                rd_ok;
   logic                rd_fail;
   logic [ADDR_W-1:0]   fail_addr;
   logic                sel_valid;
   logic [DATA_W-1:0]   sel_data;
   logic                rd_mapped;
   logic                wr_mapped;
   logic                wr_fail;

   // An address is mapped when its top SEL_W bits index an existing slave.
   function automatic logic is_mapped(input logic [ADDR_W-1:0] a);
      return {1'b0, a[ADDR_W-1 -: SEL_W]} < SLV_LIMIT;
   endfunction

   // Offset within the slave window, zero-extended back to the full width.
   function automatic logic [ADDR_W-1:0] offset_of(input logic [ADDR_W-1:0] a);
      return {{SEL_W{1'b0}}, a[OFF_W-1:0]};
   endfunction

   // One-hot slave strobe for the slave addressed by a.
   function automatic logic [N_SLAVES-1:0] onehot_of(input logic [ADDR_W-1:0] a);
      logic [N_SLAVES-1:0] oh;
      oh = '0;
      for (int i = 0; i < N_SLAVES; i++) begin
         oh[i] = (a[ADDR_W-1 -: SEL_W] == SEL_W'(i));
      end
      return oh;
   endfunction

   assign rd_mapped = is_mapped(m_rd_addr);
   assign wr_mapped = is_mapped(m_wr_addr);
   assign wr_fail   = m_wr_en & ~wr_mapped;

   // Select the valid bit and data of the slave owning the outstanding read.
   always_comb begin
      sel_valid = 1'b0;
      sel_data  = '0;
      for (int i = 0; i < N_SLAVES; i++) begin
         if (sel_q == SEL_W'(i)) begin
            sel_valid = s_rd_valid[i];
            sel_data  = s_rd_data[i*DATA_W +: DATA_W];
         end
      end
   end

   // Read FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Read FSM next state: HOLD waits for the CPU to drop its request.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (m_rd_en) state_next = rd_mapped ? WAIT : HOLD;
         WAIT:    if (sel_valid || cnt == CNT_LAST) state_next = HOLD;
         HOLD:    if (!m_rd_en) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Read FSM actions: issue a strobe, complete normally, or complete with error.
   always_comb begin
      issue     = 1'b0;
      rd_ok     = 1'b0;
      rd_fail   = 1'b0;
      fail_addr = rd_addr_q;
      case (state)
         IDLE: begin
            if (m_rd_en) begin
               if (rd_mapped) begin
                  issue = 1'b1;
               end else begin
                  rd_fail   = 1'b1;
                  fail_addr = m_rd_addr;
               end
            end
         end
         WAIT: begin
            if (sel_valid) begin
               rd_ok = 1'b1;
            end else if (cnt == CNT_LAST) begin
               rd_fail = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Registered read path: strobe, latched target, timeout counter, response.
   always_ff @(posedge clk) begin
      if (rst) begin
         s_rd_en    <= '0;
         s_rd_addr  <= '0;
         sel_q      <= '0;
         rd_addr_q  <= '0;
         cnt        <= '0;
         m_rd_valid <= 1'b0;
         m_rd_data  <= '0;
      end else begin
         s_rd_en    <= issue ? onehot_of(m_rd_addr) : '0;
         m_rd_valid <= rd_ok | rd_fail;
         if (issue) begin
            s_rd_addr <= offset_of(m_rd_addr);
            sel_q     <= m_rd_addr[ADDR_W-1 -: SEL_W];
            rd_addr_q <= m_rd_addr;
            cnt       <= '0;
         end else if (state == WAIT) begin
            cnt <= cnt + CNT_ONE;
         end
         if (rd_ok) begin
            m_rd_data <= sel_data;
         end else if (rd_fail) begin
            m_rd_data <= ERR_DATA;
         end
      end
   end

   // Registered write path: one-cycle strobe to the addressed slave.
   always_ff @(posedge clk) begin
      if (rst) begin
         s_wr_en   <= '0;
         s_wr_addr <= '0;
         s_wr_data <= '0;
      end else begin
         s_wr_en <= (m_wr_en && wr_mapped) ? onehot_of(m_wr_addr) : '0;
         if (m_wr_en && wr_mapped) begin
            s_wr_addr <= offset_of(m_wr_addr);
            s_wr_data <= m_wr_data;
         end
      end
   end

   // Sticky error flag: a new error beats a clear, and a read error's address beats a write's.
   always_ff @(posedge clk) begin
      if (rst) begin
         err      <= 1'b0;
         err_addr <= '0;
      end else begin
         if (rd_fail || wr_fail) begin
            err <= 1'b1;
         end else if (err_clr) begin
            err <= 1'b0;
         end
         if (rd_fail) begin
            err_addr <= fail_addr;
         end else if (wr_fail) begin
            err_addr <= m_wr_addr;
         end
      end
   end

endmodule

// File: tb/tb_bus_fabric.sv
// tb_bus_fabric: table-driven vectors plus hand-written corner sequences.
// Read completions are checked by a scoreboard queue filled when requests are driven.
module tb_bus_fabric;

   localparam int N  = 4;
   localparam int AW = 16;
   localparam int DW = 32;

   logic            clk = 1'b0;
   logic            rst;
   logic            m_rd_en;
   logic [AW-1:0]   m_rd_addr;
   logic [DW-1:0]   m_rd_data;
   logic            m_rd_valid;
   logic            m_wr_en;
   logic [AW-1:0]   m_wr_addr;
   logic [DW-1:0]   m_wr_data;
   logic [N-1:0]    s_rd_en;
   logic [AW-1:0]   s_rd_addr;
   logic [N*DW-1:0] s_rd_data;
   logic [N-1:0]    s_rd_valid;
   logic [N-1:0]    s_wr_en;
   logic [AW-1:0]   s_wr_addr;
   logic [DW-1:0]   s_wr_data;
   logic            err;
   logic [AW-1:0]   err_addr;
   logic            err_clr;

   logic [N-1:0]    respond;
   logic [N-1:0]    model_valid;
   logic [N-1:0]    force_valid;
   logic [DW-1:0]   base [N];

   int n_checks = 0;
   int n_fail   = 0;
   int cycle    = 0;

   typedef struct {
      logic [DW-1:0] data;
      int            start;
      int            lat;
   } exp_t;

   exp_t sb[$];

   typedef struct {
      bit            is_write;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [N-1:0]  resp;
      logic [DW-1:0] exp_data;
      int            exp_lat;
      logic [N-1:0]  exp_strobe;
      logic [AW-1:0] exp_saddr;
      logic          exp_err;
      logic [AW-1:0] exp_err_addr;
   } vec_t;

   vec_t vecs [10];

   bus_fabric dut (
      .clk        (clk),
      .rst        (rst),
      .m_rd_en    (m_rd_en),
      .m_rd_addr  (m_rd_addr),
      .m_rd_data  (m_rd_data),
      .m_rd_valid (m_rd_valid),
      .m_wr_en    (m_wr_en),
      .m_wr_addr  (m_wr_addr),
      .m_wr_data  (m_wr_data),
      .s_rd_en    (s_rd_en),
      .s_rd_addr  (s_rd_addr),
      .s_rd_data  (s_rd_data),
      .s_rd_valid (s_rd_valid),
      .s_wr_en    (s_wr_en),
      .s_wr_addr  (s_wr_addr),
      .s_wr_data  (s_wr_data),
      .err        (err),
      .err_addr   (err_addr),
      .err_clr    (err_clr)
   );

   always #5 clk = ~clk;

   // Count rising edges so read latency can be measured.
   always @(posedge clk) cycle++;

   assign s_rd_valid = model_valid | force_valid;

   // Registered slave model: answers one cycle after its strobe with base + offset.
   always @(posedge clk) begin
      model_valid <= '0;
      for (int i = 0; i < N; i++) begin
         if (s_rd_en[i] && respond[i]) begin
            model_valid[i]         <= 1'b1;
            s_rd_data[i*DW +: DW]  <= base[i] + {16'h0000, s_rd_addr};
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cycle);
      end
   endtask

   // Scoreboard consumer: every read completion must match the oldest expectation.
   always @(negedge clk) begin
      if (m_rd_valid) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL spurious_rd_valid: got m_rd_valid=1 expected 0 (no read outstanding) at cycle %0d", cycle);
         end else begin
            exp_t e;
            e = sb.pop_front();
            checkOutput("rd_data", m_rd_data, e.data);
            checkOutput("rd_latency", 32'(cycle - e.start), 32'(e.lat));
         end
      end
   end

   // Latency is counted from the negedge the request is driven: mapped reads take 3,
   // unmapped reads 1, and timeouts TIMEOUT+2 (valid at edge TIMEOUT+1 after acceptance).
   task automatic do_read(input logic [AW-1:0] addr, input logic [DW-1:0] exp_data, input int exp_lat,
                          input logic [N-1:0] exp_strobe, input logic [AW-1:0] exp_saddr, input int hold_extra);
      exp_t e;
      bit   seen;
      int   n;
      m_rd_addr = addr;
      m_rd_en   = 1'b1;
      e.data  = exp_data;
      e.start = cycle;
      e.lat   = exp_lat;
      sb.push_back(e);
      @(negedge clk);
      checkOutput("rd_strobe", 32'(s_rd_en), 32'(exp_strobe));
      if (exp_strobe != '0) checkOutput("rd_offset", 32'(s_rd_addr), 32'(exp_saddr));
      seen = m_rd_valid;
      @(negedge clk);
      checkOutput("rd_strobe_once", 32'(s_rd_en), 32'h0);
      seen = seen | m_rd_valid;
      n = 0;
      while (!seen && n < 40) begin
         @(negedge clk);
         seen = m_rd_valid;
         n++;
      end
      if (!seen) begin
         n_checks++;
         n_fail++;
         $display("[TB] FAIL rd_wait: got no m_rd_valid within 40 cycles expected one for addr %h", addr);
      end
      for (int i = 0; i < hold_extra; i++) begin
         @(negedge clk);
         checkOutput("hold_no_reissue", 32'(s_rd_en), 32'h0);
      end
      m_rd_en = 1'b0;
   endtask

   task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic [N-1:0] exp_strobe,
                           input logic [AW-1:0] exp_saddr, input logic exp_err, input logic [AW-1:0] exp_err_addr);
      m_wr_en   = 1'b1;
      m_wr_addr = addr;
      m_wr_data = data;
      @(negedge clk);
      m_wr_en = 1'b0;
      checkOutput("wr_strobe", 32'(s_wr_en), 32'(exp_strobe));
      if (exp_strobe != '0) begin
         checkOutput("wr_offset", 32'(s_wr_addr), 32'(exp_saddr));
         checkOutput("wr_data", s_wr_data, data);
      end
      checkOutput("wr_err", 32'(err), 32'(exp_err));
      if (exp_err) checkOutput("wr_err_addr", 32'(err_addr), 32'(exp_err_addr));
      @(negedge clk);
      checkOutput("wr_strobe_once", 32'(s_wr_en), 32'h0);
   endtask

   task automatic clear_err();
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      checkOutput("err_clr", 32'(err), 32'h0);
   endtask

   task automatic check_reset(input string tag);
      checkOutput({tag, "_m_rd_valid"}, 32'(m_rd_valid), 32'h0);
      checkOutput({tag, "_m_rd_data"}, m_rd_data, 32'h0);
      checkOutput({tag, "_s_rd_en"}, 32'(s_rd_en), 32'h0);
      checkOutput({tag, "_s_rd_addr"}, 32'(s_rd_addr), 32'h0);
      checkOutput({tag, "_s_wr_en"}, 32'(s_wr_en), 32'h0);
      checkOutput({tag, "_s_wr_addr"}, 32'(s_wr_addr), 32'h0);
      checkOutput({tag, "_s_wr_data"}, s_wr_data, 32'h0);
      checkOutput({tag, "_err"}, 32'(err), 32'h0);
      checkOutput({tag, "_err_addr"}, 32'(err_addr), 32'h0);
   endtask

   task automatic applyStimulus(input vec_t v);
      respond = v.resp;
      if (v.is_write) begin
         do_write(v.addr, v.wdata, v.exp_strobe, v.exp_saddr, v.exp_err, v.exp_err_addr);
      end else begin
         do_read(v.addr, v.exp_data, v.exp_lat, v.exp_strobe, v.exp_saddr, 0);
         checkOutput("rd_err", 32'(err), 32'(v.exp_err));
         if (v.exp_err) checkOutput("rd_err_addr", 32'(err_addr), 32'(v.exp_err_addr));
      end
      clear_err();
   endtask

   // Safety net so a wedged run still terminates.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got simulation still running expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      base[0] = 32'h12345674;
      base[1] = 32'hA0000000;
      base[2] = 32'hB0000000;
      base[3] = 32'hC0000000;

      //          wr  addr      wdata         resp     exp_data      lat strobe   saddr     err   err_addr
      vecs[0] = '{0, 16'h0004, 32'h00000000, 4'b1111, 32'h12345678, 3,  4'b0001, 16'h0004, 1'b0, 16'h0000};
      vecs[1] = '{0, 16'h1234, 32'h00000000, 4'b1111, 32'hA0000234, 3,  4'b0010, 16'h0234, 1'b0, 16'h0000};
      vecs[2] = '{0, 16'h3FFF, 32'h00000000, 4'b1111, 32'hC0000FFF, 3,  4'b1000, 16'h0FFF, 1'b0, 16'h0000};
      vecs[3] = '{0, 16'h2000, 32'h00000000, 4'b1011, 32'hDEADBEEF, 17, 4'b0100, 16'h0000, 1'b1, 16'h2000};
      vecs[4] = '{0, 16'h4000, 32'h00000000, 4'b1111, 32'hDEADBEEF, 1,  4'b0000, 16'h0000, 1'b1, 16'h4000};
      vecs[5] = '{0, 16'hF123, 32'h00000000, 4'b1111, 32'hDEADBEEF, 1,  4'b0000, 16'h0000, 1'b1, 16'hF123};
      vecs[6] = '{1, 16'h1000, 32'h00100000, 4'b1111, 32'h00000000, 0,  4'b0010, 16'h0000, 1'b0, 16'h0000};
      vecs[7] = '{1, 16'h5000, 32'h12121212, 4'b1111, 32'h00000000, 0,  4'b0000, 16'h0000, 1'b1, 16'h5000};
      vecs[8] = '{1, 16'h3ABC, 32'hCAFEF00D, 4'b1111, 32'h00000000, 0,  4'b1000, 16'h0ABC, 1'b0, 16'h0000};
      vecs[9] = '{0, 16'h2ABC, 32'h00000000, 4'b1111, 32'hB0000ABC, 3,  4'b0100, 16'h0ABC, 1'b0, 16'h0000};

      rst         = 1'b1;
      m_rd_en     = 1'b0;
      m_rd_addr   = '0;
      m_wr_en     = 1'b0;
      m_wr_addr   = '0;
      m_wr_data   = '0;
      err_clr     = 1'b0;
      respond     = 4'b1111;
      force_valid = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check_reset("init");

      for (int i = 0; i < 10; i++) begin
         applyStimulus(vecs[i]);
      end
      respond = 4'b1111;

      // CPU keeps m_rd_en high after completion: no re-issue until it drops and rises again.
      do_read(16'h0008, 32'h1234567C, 3, 4'b0001, 16'h0008, 3);
      @(negedge clk);
      checkOutput("hold_drop_no_strobe", 32'(s_rd_en), 32'h0);
      do_read(16'h0008, 32'h1234567C, 3, 4'b0001, 16'h0008, 0);
      @(negedge clk);

      // Valid from slaves other than the selected one must not complete the read.
      respond = 4'b0000;
      fork
         do_read(16'h0020, 32'hDEADBEEF, 17, 4'b0001, 16'h0020, 0);
         begin
            repeat (3) @(negedge clk);
            force_valid = 4'b1110;
            @(negedge clk);
            force_valid = '0;
         end
      join
      checkOutput("other_valid_err", 32'(err), 32'h1);
      checkOutput("other_valid_err_addr", 32'(err_addr), 32'h0020);
      clear_err();
      respond = 4'b1111;

      // Read and write in the same cycle are both serviced.
      fork
         do_read(16'h3004, 32'hC0000004, 3, 4'b1000, 16'h0004, 0);
         begin
            m_wr_en   = 1'b1;
            m_wr_addr = 16'h0040;
            m_wr_data = 32'h55AA55AA;
            @(negedge clk);
            m_wr_en = 1'b0;
            checkOutput("rw_wr_strobe", 32'(s_wr_en), 32'h1);
            checkOutput("rw_wr_addr", 32'(s_wr_addr), 32'h0040);
            checkOutput("rw_wr_data", s_wr_data, 32'h55AA55AA);
         end
      join
      @(negedge clk);

      // Read error and write error together: err_addr keeps the read address.
      m_rd_addr = 16'h8000;
      m_rd_en   = 1'b1;
      sb.push_back('{32'hDEADBEEF, cycle, 1});
      m_wr_addr = 16'h9000;
      m_wr_en   = 1'b1;
      @(negedge clk);
      m_wr_en = 1'b0;
      m_rd_en = 1'b0;
      checkOutput("dual_err", 32'(err), 32'h1);
      checkOutput("dual_err_addr", 32'(err_addr), 32'h8000);
      checkOutput("dual_no_wr_strobe", 32'(s_wr_en), 32'h0);
      @(negedge clk);
      clear_err();

      // err_clr in the same cycle as a new error: the error wins.
      do_write(16'h5000, 32'h0, 4'b0000, 16'h0000, 1'b1, 16'h5000);
      err_clr   = 1'b1;
      m_wr_en   = 1'b1;
      m_wr_addr = 16'hF000;
      @(negedge clk);
      err_clr = 1'b0;
      m_wr_en = 1'b0;
      checkOutput("clr_vs_err", 32'(err), 32'h1);
      checkOutput("clr_vs_err_addr", 32'(err_addr), 32'hF000);
      checkOutput("clr_vs_err_no_strobe", 32'(s_wr_en), 32'h0);
      clear_err();

      // Reset while a read waits on slave 1; its late valid must be ignored.
      respond   = 4'b1101;
      m_rd_addr = 16'h1010;
      m_rd_en   = 1'b1;
      @(negedge clk);
      checkOutput("rst_pre_strobe", 32'(s_rd_en), 32'h2);
      @(negedge clk);
      rst     = 1'b1;
      m_rd_en = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      check_reset("midread");
      force_valid = 4'b0010;
      @(negedge clk);
      force_valid = '0;
      checkOutput("late_valid_ignored", 32'(m_rd_valid), 32'h0);
      repeat (2) @(negedge clk);
      respond = 4'b1111;
      do_read(16'h1010, 32'hA0000010, 3, 4'b0010, 16'h0010, 0);
      repeat (3) @(negedge clk);

      checkOutput("sb_empty", 32'(sb.size()), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/bus_fabric.md
# bus_fabric

Parametrised single-master bus interconnect between the CPU port and N memory-mapped slaves (RAM, LED, future peripherals). It replaces the combinational arbiter inside `machine`. It adds registered request and response paths, a read FSM that tracks one outstanding read, and a per-read timeout. Unmapped or non-responding accesses complete with an error word and set a sticky error flag, so a bad access can no longer hang the CPU.

## Interface
- `N_SLAVES`, default 4: number of slave ports; legal range 1..2^`SEL_W`.
- `ADDR_W`, default 16: address width, master and slave side.
- `SEL_W`, default 4: number of top address bits used as the slave index.
- `DATA_W`, default 32: data width.
- `TIMEOUT`, default 15: cycles to wait for a slave `rd_valid` before returning an error; must be ≥1.
- `ERR_DATA`, default 32'hDEADBEEF: read data returned on any error.

Ports:
- `clk` in 1: clock; all logic on posedge.
- `rst` in 1: synchronous, active-high reset.
- `m_rd_en` in 1: master read request; held high until `m_rd_valid` is seen.
- `m_rd_addr` in `ADDR_W`: master read address.
- `m_rd_data` out `DATA_W`: read data; valid only when `m_rd_valid` is high.
- `m_rd_valid` out 1: one-cycle read-complete pulse.
- `m_wr_en`, `m_wr_addr`, `m_wr_data` in 1 / `ADDR_W` / `DATA_W`: master write, single cycle.
- `s_rd_en` out `N_SLAVES`: one-hot slave read strobe.
- `s_rd_addr` out `ADDR_W`: slave offset, shared by all slaves.
- `s_rd_data` in `N_SLAVES*DATA_W`: slave i occupies bits [i*DATA_W +: DATA_W].
- `s_rd_valid` in `N_SLAVES`: per-slave read-valid.
- `s_wr_en` out `N_SLAVES`; `s_wr_addr` out `ADDR_W`; `s_wr_data` out `DATA_W`: slave write port.
- `err` out 1: sticky error flag.
- `err_addr` out `ADDR_W`: address of the most recent error.
- `err_clr` in 1: clears `err`.

## Operation
- Decode: index = addr[ADDR_W-1 -: SEL_W]. The access is mapped if index < `N_SLAVES`. Offset = addr[ADDR_W-SEL_W-1:0], zero-extended to `ADDR_W`.
- Read FSM states: IDLE, WAIT, HOLD.
  - IDLE: when `m_rd_en`=1 is sampled:
    - Mapped address: latch index, drive `s_rd_addr`=offset, assert `s_rd_en[index]` for exactly one cycle, clear the timeout counter, go to WAIT.
    - Unmapped address: issue an error response next cycle, go to HOLD.
  - WAIT: the counter increments every cycle.
    - `s_rd_valid[index]`=1: register `m_rd_data` = that slave's data, pulse `m_rd_valid`, go to HOLD.
    - Counter reaches `TIMEOUT` with no valid: issue an error response, go to HOLD.
    - Valid from non-selected slaves is ignored.
  - HOLD: stay until `m_rd_en` is sampled 0, then go to IDLE. This prevents re-issuing a request the CPU has not yet dropped.
- Error response: `m_rd_data`=`ERR_DATA`, one-cycle `m_rd_valid`, `err`←1, `err_addr`←the read address.
- Writes are independent of the read FSM.
  - `m_wr_en` sampled 1 with a mapped address: next cycle `s_wr_en[index]`=1 for one cycle, with `s_wr_addr`=offset and `s_wr_data` registered.
  - Unmapped write: no slave strobe; `err`←1, `err_addr`←the write address.
- Priority rules:
  - A read error and a write error in the same cycle: `err_addr` takes the read address.
  - `err_clr` and a new error in the same cycle: the error wins, so `err` stays 1.
  - A read and a write in the same cycle are both serviced.
- `s_rd_valid` sampled outside WAIT is ignored.

## Timing
- Reset values: all outputs 0 (`m_rd_data`, `m_rd_valid`, `s_*_en`, `s_*_addr`, `s_wr_data`, `err`, `err_addr`); FSM in IDLE; counter 0.
- Reset mid-read: the pending read is dropped with no `m_rd_valid`; a late slave valid after reset is ignored.
- Read latency, edge numbering, mapped slave with 1-cycle registered response:
  - `m_rd_en` sampled at edge 0.
  - `s_rd_en` high from edge 0 to edge 1.
  - Slave valid sampled at edge 2.
  - `m_rd_valid` high from edge 2 to edge 3.
  - Total: 3 cycles request-to-valid.
- Unmapped read: `m_rd_valid` high in the cycle after acceptance.
- Timeout read: `m_rd_valid` (error) asserts `TIMEOUT`+1 cycles after acceptance.
- Write latency: 1 cycle from master to slave strobe; no back-pressure.
- `m_rd_valid` is never high for more than one consecutive cycle.

## Test plan
- Read 0x0004 from slave 0, which returns 0x12345678 one cycle after strobe → `s_rd_en`=4'b0001 for 1 cycle, `s_rd_addr`=0x0004, `m_rd_valid` 3 cycles after request with 0x12345678, `err`=0.
- Write 0x1000 data 0x00100000 → `s_wr_en`=4'b0010, `s_wr_addr`=0, `s_wr_data`=0x00100000 next cycle; write to 0x5000 (N=4) → no strobe, `err`=1, `err_addr`=0x5000.
- Read 0x2000 with slave 2 never responding, `TIMEOUT`=15 → `m_rd_valid` with 0xDEADBEEF 16 cycles after acceptance, `err_addr`=0x2000; then `err_clr` → `err`=0.
- Hold `m_rd_en` high 3 cycles after `m_rd_valid` → no second `s_rd_en` until `m_rd_en` drops and is re-raised.
- Assert `rst` during WAIT, then slave 1 asserts `s_rd_valid` → no `m_rd_valid`; all outputs 0; the next read completes normally.
- Same cycle: `err_clr`=1 plus an unmapped write to 0xF000 → `err` stays 1, `err_addr`=0xF000.
